// File: rtl/timer_compare.sv
// Compare/alarm unit on the peripheral bus: raises IRQ when TIME_COUNTER reaches CMP (wrap-tolerant).
// Optional periodic re-arm (PERIOD register, CTRL.PERIODIC/OVR) under `TIMER_COMPARE_PERIODIC_EN.
module timer_compare #(
  parameter logic [31:0] CMP_RESET = 32'hFFFF_FFFF
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic [31:0] TIME_COUNTER,
  input  logic        BUS_EN,
  input  logic        BUS_WE,
  input  logic [2:0]  BUS_ADDR,
  input  logic [31:0] BUS_WDATA,
  output logic [31:0] BUS_RDATA,
  output logic        IRQ
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FIRED = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic [31:0] cmp;
  logic        ctrl_enable;
  logic        ctrl_irq_en;
  logic        status_fired;
  logic        ctrl_periodic;
  logic        ctrl_ovr;
  logic [31:0] diff;
  logic        reached;
  logic        wr, rd;
  logic        wr_cmp, wr_ctrl, wr_stat;
  logic        ctrl_dis, ctrl_arm, clr;
  logic        fire, per_fire;
  logic [31:0] rd_mux;

  assign wr       = BUS_EN & BUS_WE;
  assign rd       = BUS_EN & ~BUS_WE;
  assign wr_cmp   = wr & (BUS_ADDR == 3'd1);
  assign wr_ctrl  = wr & (BUS_ADDR == 3'd2);
  assign wr_stat  = wr & (BUS_ADDR == 3'd3);
  assign ctrl_dis = wr_ctrl & ~BUS_WDATA[0];
  assign ctrl_arm = wr_ctrl & BUS_WDATA[0];
  assign clr      = wr_stat & BUS_WDATA[0];

  // Signed distance past the deadline; non-negative means reached, valid for horizons < 2^31.
  assign diff    = TIME_COUNTER - cmp;
  assign reached = ~diff[31];

  // A disabling CTRL write in the same cycle suppresses the fire.
  assign fire = (state == ARMED) & reached & ~ctrl_dis;

`ifdef TIMER_COMPARE_PERIODIC_EN
  logic [31:0] period;
  logic        wr_period;

  assign wr_period = wr & (BUS_ADDR == 3'd4);
  // PERIOD=0 degrades to one-shot so the unit never sits re-firing on the same CMP.
  assign per_fire  = fire & ctrl_periodic & (period != 32'd0);

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      period        <= 32'd0;
      ctrl_periodic <= 1'b0;
      ctrl_ovr      <= 1'b0;
    end else begin
      if (wr_period) period <= BUS_WDATA;
      if (wr_ctrl) ctrl_periodic <= BUS_WDATA[2];
      if (fire & status_fired) ctrl_ovr <= 1'b1;
      else if (clr)            ctrl_ovr <= 1'b0;
    end
  end
`else
  assign per_fire      = 1'b0;
  assign ctrl_periodic = 1'b0;
  assign ctrl_ovr      = 1'b0;
`endif

  always_ff @(posedge CLK) begin
    if (!RESETN) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (ctrl_arm) state_nxt = ARMED;
      ARMED: begin
        if (ctrl_dis)                          state_nxt = IDLE;
        else if (fire & ~per_fire & ~wr_ctrl)  state_nxt = FIRED;
      end
      FIRED: begin
        if (ctrl_arm) state_nxt = ARMED;
        else if (clr) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN) begin
      cmp          <= CMP_RESET;
      ctrl_enable  <= 1'b0;
      ctrl_irq_en  <= 1'b0;
      status_fired <= 1'b0;
    end else begin
      // A bus write to CMP takes priority over the periodic advance.
      if (wr_cmp)        cmp <= BUS_WDATA;
`ifdef TIMER_COMPARE_PERIODIC_EN
      else if (per_fire) cmp <= cmp + period;
`endif
      if (wr_ctrl) begin
        ctrl_enable <= BUS_WDATA[0];
        ctrl_irq_en <= BUS_WDATA[1];
      end else if (fire & ~per_fire) begin
        ctrl_enable <= 1'b0;
      end
      if (fire)     status_fired <= 1'b1;
      else if (clr) status_fired <= 1'b0;
    end
  end

  always_comb begin
    rd_mux = 32'd0;
    case (BUS_ADDR)
      3'd0: rd_mux = TIME_COUNTER;
      3'd1: rd_mux = cmp;
      3'd2: rd_mux = {28'd0, ctrl_ovr, ctrl_periodic, ctrl_irq_en, ctrl_enable};
      3'd3: rd_mux = {31'd0, status_fired};
`ifdef TIMER_COMPARE_PERIODIC_EN
      3'd4: rd_mux = period;
`endif
      default: rd_mux = 32'd0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETN)  BUS_RDATA <= 32'd0;
    else if (rd)  BUS_RDATA <= rd_mux;
  end

  assign IRQ = status_fired & ctrl_irq_en;

endmodule

// File: tb/tb_timer_compare.sv
// Directed bench for timer_compare; TIME_COUNTER is driven by the bench and advances once per cycle.
module tb_timer_compare;

  logic        clk;
  logic        resetn;
  logic [31:0] tc;
  logic        bus_en, bus_we;
  logic [2:0]  bus_addr;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        irq;

  int n_tests = 0;
  int n_fail  = 0;

  timer_compare dut (
    .CLK          (clk),
    .RESETN       (resetn),
    .TIME_COUNTER (tc),
    .BUS_EN       (bus_en),
    .BUS_WE       (bus_we),
    .BUS_ADDR     (bus_addr),
    .BUS_WDATA    (bus_wdata),
    .BUS_RDATA    (bus_rdata),
    .IRQ          (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One clock; inputs change 1ns after the edge, and the timer advances with it.
  task automatic cyc();
    @(posedge clk);
    #1;
    tc = tc + 32'd1;
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
    cyc();
    bus_en = 1'b0; bus_we = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus_en = 1'b1; bus_we = 1'b0; bus_addr = a;
    cyc();
    bus_en = 1'b0;
    d = bus_rdata;
  endtask

  task automatic wait_tc(input logic [31:0] t);
    int n;
    n = 0;
    while (tc != t && n < 1000) begin
      cyc();
      n++;
    end
    chk("wait_tc", tc, t);
  endtask

  logic [31:0] rv;
  logic [31:0] texp;
  logic        early;

  initial begin
    resetn = 1'b0; bus_en = 1'b0; bus_we = 1'b0; bus_addr = 3'd0; bus_wdata = 32'd0;
    tc = 32'd7;
    cyc(); cyc();
    chk("rst_irq", {31'd0, irq}, 32'd0);
    chk("rst_rdata", bus_rdata, 32'd0);
    resetn = 1'b1;

    // Register map after reset
    texp = tc;
    bus_read(3'd0, rv); chk("rd_time", rv, texp);
    bus_read(3'd1, rv); chk("rd_cmp_rst", rv, 32'hFFFF_FFFF);
    bus_read(3'd2, rv); chk("rd_ctrl_rst", rv, 32'd0);
    bus_read(3'd3, rv); chk("rd_stat_rst", rv, 32'd0);
    bus_read(3'd6, rv); chk("rd_unmapped", rv, 32'd0);
    chk("irq_rst", {31'd0, irq}, 32'd0);

    // Address 4 and CTRL bits 2/3
    bus_write(3'd4, 32'd5);
    bus_read(3'd4, rv);
`ifdef TIMER_COMPARE_PERIODIC_EN
    chk("rd_period", rv, 32'd5);
`else
    chk("rd_addr4", rv, 32'd0);
`endif
    bus_write(3'd2, 32'h0000_000C);
    bus_read(3'd2, rv);
`ifdef TIMER_COMPARE_PERIODIC_EN
    chk("ctrl_hi_bits", rv, 32'd4);
`else
    chk("ctrl_hi_bits", rv, 32'd0);
`endif
    bus_write(3'd2, 32'd0);
    bus_write(3'd4, 32'd0);

    // Basic one-shot: CMP=100 armed at TIME=50
    tc = 32'd50;
    bus_write(3'd1, 32'd100);
    bus_write(3'd2, 32'd3);
    wait_tc(32'd100);
    chk("irq_before_fire", {31'd0, irq}, 32'd0);
    cyc();
    chk("irq_fire100", {31'd0, irq}, 32'd1);
    bus_read(3'd2, rv); chk("ctrl_after_fire", rv, 32'd2);
    bus_read(3'd3, rv); chk("stat_fired", rv, 32'd1);
    bus_write(3'd3, 32'd0);
    chk("w0c_no_effect", {31'd0, irq}, 32'd1);
    bus_write(3'd3, 32'd1);
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    bus_read(3'd3, rv); chk("stat_cleared", rv, 32'd0);

    // Wrap: CMP=4 armed just before wrap
    tc = 32'hFFFF_FFF8;
    bus_write(3'd1, 32'd4);
    bus_write(3'd2, 32'd3);
    early = 1'b0;
    for (int i = 0; i < 40 && tc != 32'd4; i++) begin
      if (irq) early = 1'b1;
      cyc();
    end
    if (irq) early = 1'b1;
    chk("wrap_no_early", {31'd0, early}, 32'd0);
    chk("wrap_at4", tc, 32'd4);
    cyc();
    chk("wrap_fire", {31'd0, irq}, 32'd1);
    bus_write(3'd3, 32'd1);

    // Stale CMP in the past fires on the first ARMED cycle
    tc = 32'hFFFF_FFF8;
    bus_write(3'd1, 32'hFFFF_FFF0);
    bus_write(3'd2, 32'd3);
    chk("stale_arm_edge", {31'd0, irq}, 32'd0);
    cyc();
    chk("stale_fire", {31'd0, irq}, 32'd1);

    // Re-arm from FIRED, then fire and W1C land in the same cycle: set wins
    bus_write(3'd2, 32'd3);
    bus_write(3'd3, 32'd1);
    chk("clr_vs_fire_irq", {31'd0, irq}, 32'd1);
    bus_read(3'd3, rv); chk("clr_vs_fire_stat", rv, 32'd1);
    bus_write(3'd3, 32'd1);
    chk("clr_after", {31'd0, irq}, 32'd0);

    // ENABLE=0 write on the reaching edge suppresses the fire
    tc = 32'd1000;
    bus_write(3'd1, 32'd1010);
    bus_write(3'd2, 32'd3);
    wait_tc(32'd1010);
    bus_write(3'd2, 32'd2);
    chk("dis_vs_fire_irq", {31'd0, irq}, 32'd0);
    cyc(); cyc(); cyc();
    chk("dis_later_irq", {31'd0, irq}, 32'd0);
    bus_read(3'd3, rv); chk("dis_stat", rv, 32'd0);
    bus_read(3'd2, rv); chk("dis_ctrl", rv, 32'd2);

    // CMP write on the reaching edge: old CMP is evaluated
    tc = 32'd1990;
    bus_write(3'd1, 32'd2000);
    bus_write(3'd2, 32'd3);
    wait_tc(32'd2000);
    bus_write(3'd1, 32'd5000);
    chk("cmpwr_vs_fire", {31'd0, irq}, 32'd1);
    bus_read(3'd1, rv); chk("cmpwr_new", rv, 32'd5000);
    bus_write(3'd3, 32'd1);
    chk("cmpwr_clr", {31'd0, irq}, 32'd0);

`ifdef TIMER_COMPARE_PERIODIC_EN
    // Periodic: fires at 10, 15, 20 with no clear in between
    tc = 32'd1;
    bus_write(3'd4, 32'd5);
    bus_write(3'd1, 32'd10);
    bus_write(3'd2, 32'd7);
    wait_tc(32'd10);
    cyc();
    chk("per_fire1", {31'd0, irq}, 32'd1);
    wait_tc(32'd21);
    bus_read(3'd1, rv); chk("per_cmp25", rv, 32'd25);
    bus_read(3'd2, rv); chk("per_ctrl_ovr", rv, 32'hF);
    bus_write(3'd3, 32'd1);
    bus_read(3'd2, rv); chk("per_ovr_clr", rv, 32'd7);
    bus_write(3'd2, 32'd0);
    chk("per_stop_irq", {31'd0, irq}, 32'd0);
`endif

    // Reset with IRQ pending
    tc = 32'd3000;
    bus_write(3'd1, 32'd2990);
    bus_write(3'd2, 32'd3);
    cyc();
    chk("pre_rst_irq", {31'd0, irq}, 32'd1);
    bus_read(3'd2, rv); chk("pre_rst_rdata", rv, 32'd2);
    resetn = 1'b0;
    cyc();
    chk("mid_rst_irq", {31'd0, irq}, 32'd0);
    chk("mid_rst_rdata", bus_rdata, 32'd0);
    resetn = 1'b1;
    bus_read(3'd1, rv); chk("post_rst_cmp", rv, 32'hFFFF_FFFF);
    bus_read(3'd2, rv); chk("post_rst_ctrl", rv, 32'd0);
    bus_read(3'd3, rv); chk("post_rst_stat", rv, 32'd0);
    chk("post_rst_irq", {31'd0, irq}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
